// File: rtl/alu_op_sequencer.sv
// Valid/ready front end for a combinational 4-bit ALU: registers operands, waits a settle window,
// captures R/overflow into a response slot. Optional op counter under `ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned MODE_W        = 3,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ALU_SEQ_STATS_EN
  output logic [7:0]        op_count_o,
`endif
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [WIDTH-1:0]  req_a_i,
  input  logic [WIDTH-1:0]  req_b_i,
  input  logic              req_c_i,
  input  logic [MODE_W-1:0] req_mode_i,
  output logic [WIDTH-1:0]  alu_a_o,
  output logic [WIDTH-1:0]  alu_b_o,
  output logic              alu_c_o,
  output logic [MODE_W-1:0] alu_mode_o,
  input  logic [WIDTH-1:0]  alu_r_i,
  input  logic              alu_ovf_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [WIDTH-1:0]  resp_r_o,
  output logic              resp_ovf_o
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gen_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                alu_c_q, alu_c_d;
  logic [MODE_W-1:0]   alu_mode_q, alu_mode_d;
  logic [WIDTH-1:0]    resp_r_q, resp_r_d;
  logic                resp_ovf_q, resp_ovf_d;
  logic                resp_hs;

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_hs      = resp_valid_o && resp_ready_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_c_d    = alu_c_q;
    alu_mode_d = alu_mode_q;
    resp_r_d   = resp_r_q;
    resp_ovf_d = resp_ovf_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          alu_a_d    = req_a_i;
          alu_b_d    = req_b_i;
          alu_c_d    = req_c_i;
          alu_mode_d = req_mode_i;
          cnt_d      = CntInit;
          state_d    = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == 4'd0) begin
          resp_r_d   = alu_r_i;
          resp_ovf_d = alu_ovf_i;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        // A request pending in this cycle is not taken; req_ready is low until IDLE.
        if (resp_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_c_q    <= 1'b0;
      alu_mode_q <= '0;
      resp_r_q   <= '0;
      resp_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_c_q    <= alu_c_d;
      alu_mode_q <= alu_mode_d;
      resp_r_q   <= resp_r_d;
      resp_ovf_q <= resp_ovf_d;
    end
  end

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_c_o    = alu_c_q;
  assign alu_mode_o = alu_mode_q;
  assign resp_r_o   = resp_r_q;
  assign resp_ovf_o = resp_ovf_q;

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (resp_hs && op_count_q != 8'hFF) op_count_d = op_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= 8'd0;
    else        op_count_q <= op_count_d;
  end

  assign op_count_o = op_count_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: two instances (settle 1 and 3) sharing stimulus,
// each with an XOR stub ALU (R = A ^ B, ovf = C).
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_a = 4'h0, req_b = 4'h0;
  logic       req_c = 1'b0;
  logic [2:0] req_mode = 3'd0;
  logic       resp_ready = 1'b0;

  logic       s1_req_ready, s1_alu_c, s1_resp_valid, s1_resp_ovf;
  logic [3:0] s1_alu_a, s1_alu_b, s1_resp_r;
  logic [2:0] s1_alu_mode;
  logic       s3_req_ready, s3_alu_c, s3_resp_valid, s3_resp_ovf;
  logic [3:0] s3_alu_a, s3_alu_b, s3_resp_r;
  logic [2:0] s3_alu_mode;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0] s1_op_count, s3_op_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(4), .MODE_W(3), .SETTLE_CYCLES(1)) u_s1 (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ALU_SEQ_STATS_EN
    .op_count_o  (s1_op_count),
`endif
    .req_valid_i (req_valid),
    .req_ready_o (s1_req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_c_i     (req_c),
    .req_mode_i  (req_mode),
    .alu_a_o     (s1_alu_a),
    .alu_b_o     (s1_alu_b),
    .alu_c_o     (s1_alu_c),
    .alu_mode_o  (s1_alu_mode),
    .alu_r_i     (s1_alu_a ^ s1_alu_b),
    .alu_ovf_i   (s1_alu_c),
    .resp_valid_o(s1_resp_valid),
    .resp_ready_i(resp_ready),
    .resp_r_o    (s1_resp_r),
    .resp_ovf_o  (s1_resp_ovf)
  );

  alu_op_sequencer #(.WIDTH(4), .MODE_W(3), .SETTLE_CYCLES(3)) u_s3 (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ALU_SEQ_STATS_EN
    .op_count_o  (s3_op_count),
`endif
    .req_valid_i (req_valid),
    .req_ready_o (s3_req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_c_i     (req_c),
    .req_mode_i  (req_mode),
    .alu_a_o     (s3_alu_a),
    .alu_b_o     (s3_alu_b),
    .alu_c_o     (s3_alu_c),
    .alu_mode_o  (s3_alu_mode),
    .alu_r_i     (s3_alu_a ^ s3_alu_b),
    .alu_ovf_i   (s3_alu_c),
    .resp_valid_o(s3_resp_valid),
    .resp_ready_i(resp_ready),
    .resp_r_o    (s3_resp_r),
    .resp_ovf_o  (s3_resp_ovf)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [17:0] s1_all, s3_all;
    req_valid = 1'b1;
    req_a = 4'hF;
    req_b = 4'h3;
    req_c = 1'b1;
    req_mode = 3'd7;
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    s1_all = {s1_alu_a, s1_alu_b, s1_alu_c, s1_alu_mode, s1_resp_valid, s1_resp_r, s1_resp_ovf};
    s3_all = {s3_alu_a, s3_alu_b, s3_alu_c, s3_alu_mode, s3_resp_valid, s3_resp_r, s3_resp_ovf};
    total++;
    if (s1_all !== 18'd0) begin
      bad++;
      $display("FAIL reset_s1_outputs: got %0h want 0", s1_all);
    end
    total++;
    if (s3_all !== 18'd0) begin
      bad++;
      $display("FAIL reset_s3_outputs: got %0h want 0", s3_all);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if ({s1_req_ready, s3_req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL reset_req_ready: got %b want 11", {s1_req_ready, s3_req_ready});
    end
    total++;
    if ({s1_resp_valid, s1_alu_a, s3_resp_valid, s3_alu_a} !== 10'd0) begin
      bad++;
      $display("FAIL reset_no_txn: got %0h want 0",
               {s1_resp_valid, s1_alu_a, s3_resp_valid, s3_alu_a});
    end
  endtask

  task automatic test_settle1();
    do_reset();
    resp_ready = 1'b1;
    req_a = 4'b0101;
    req_b = 4'b1010;
    req_c = 1'b1;
    req_mode = 3'b000;
    req_valid = 1'b1;
    tick();  // edge k
    req_valid = 1'b0;
    total++;
    if ({s1_alu_a, s1_alu_b, s1_alu_c, s1_req_ready, s1_resp_valid} !== {4'b0101, 4'b1010, 3'b100})
    begin
      bad++;
      $display("FAIL s1_accept: got %0h want %0h",
               {s1_alu_a, s1_alu_b, s1_alu_c, s1_req_ready, s1_resp_valid},
               {4'b0101, 4'b1010, 3'b100});
    end
    tick();  // edge k+1
    total++;
    if ({s1_resp_valid, s1_resp_r, s1_resp_ovf} !== {1'b1, 4'b1111, 1'b1}) begin
      bad++;
      $display("FAIL s1_resp: got %b want 1_1111_1", {s1_resp_valid, s1_resp_r, s1_resp_ovf});
    end
    tick();  // edge k+2
    total++;
    if ({s1_resp_valid, s1_req_ready, s1_alu_a} !== {2'b01, 4'b0101}) begin
      bad++;
      $display("FAIL s1_clear: got %b want 01_0101", {s1_resp_valid, s1_req_ready, s1_alu_a});
    end
  endtask

  task automatic test_settle3();
    do_reset();
    resp_ready = 1'b1;
    req_a = 4'b1100;
    req_b = 4'b1100;
    req_c = 1'b0;
    req_mode = 3'b101;
    req_valid = 1'b1;
    tick();  // edge k
    req_valid = 1'b0;
    total++;
    if ({s3_alu_a, s3_alu_mode, s3_alu_c} !== {4'b1100, 3'b101, 1'b0}) begin
      bad++;
      $display("FAIL s3_accept: got %b want 1100_101_0", {s3_alu_a, s3_alu_mode, s3_alu_c});
    end
    tick();
    tick();  // edge k+2
    total++;
    if (s3_resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL s3_early_resp: got %b want 0", s3_resp_valid);
    end
    tick();  // edge k+3
    total++;
    if ({s3_resp_valid, s3_resp_r, s3_resp_ovf} !== {1'b1, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL s3_resp: got %b want 1_0000_0", {s3_resp_valid, s3_resp_r, s3_resp_ovf});
    end
  endtask

  task automatic test_backpressure();
    int errs;
    do_reset();
    resp_ready = 1'b0;
    req_a = 4'h3;
    req_b = 4'h5;
    req_c = 1'b1;
    req_mode = 3'd2;
    req_valid = 1'b1;
    tick();  // accept first
    req_a = 4'h9;
    req_b = 4'h1;
    req_c = 1'b0;
    tick();
    tick();
    tick();  // resp_valid rises
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if ({s3_resp_valid, s3_resp_r, s3_resp_ovf, s3_req_ready, s3_alu_a} !==
          {1'b1, 4'h6, 1'b1, 1'b0, 4'h3}) errs++;
      tick();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bp_stall: got %0d bad cycles want 0", errs);
    end
    total++;
    if ({s3_resp_valid, s3_resp_r} !== {1'b1, 4'h6}) begin
      bad++;
      $display("FAIL bp_hold: got %b want 1_0110", {s3_resp_valid, s3_resp_r});
    end
    resp_ready = 1'b1;
    tick();  // response handshake; held request must not be taken here
    total++;
    if ({s3_resp_valid, s3_req_ready, s3_alu_a} !== {2'b01, 4'h3}) begin
      bad++;
      $display("FAIL bp_handshake: got %b want 01_0011", {s3_resp_valid, s3_req_ready, s3_alu_a});
    end
    tick();  // second request accepted
    total++;
    if ({s3_alu_a, s3_alu_b, s3_req_ready} !== {4'h9, 4'h1, 1'b0}) begin
      bad++;
      $display("FAIL bp_second_accept: got %b want 1001_0001_0", {s3_alu_a, s3_alu_b, s3_req_ready});
    end
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if ({s3_resp_valid, s3_resp_r, s3_resp_ovf} !== {1'b1, 4'h8, 1'b0}) begin
      bad++;
      $display("FAIL bp_second_resp: got %b want 1_1000_0", {s3_resp_valid, s3_resp_r, s3_resp_ovf});
    end
  endtask

  task automatic test_abort();
    int errs;
    do_reset();
    resp_ready = 1'b1;
    req_a = 4'h7;
    req_b = 4'h1;
    req_c = 1'b1;
    req_mode = 3'd4;
    req_valid = 1'b1;
    tick();  // accept
    req_valid = 1'b0;
    tick();  // mid-DRIVE
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({s3_alu_a, s3_alu_b, s3_alu_c, s3_alu_mode, s3_resp_valid, s3_resp_r, s3_resp_ovf,
         s3_req_ready} !== 19'd1) begin
      bad++;
      $display("FAIL abort_zero: got %0h want 1",
               {s3_alu_a, s3_alu_b, s3_alu_c, s3_alu_mode, s3_resp_valid, s3_resp_r,
                s3_resp_ovf, s3_req_ready});
    end
    tick();
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({s3_resp_valid, s3_req_ready} !== 2'b01) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL abort_no_resp: got %0d bad cycles want 0", errs);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    resp_ready = 1'b1;
    req_a = 4'h2;
    req_b = 4'h4;
    req_c = 1'b0;
    req_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s1_resp_valid === 1'b1) n++;
    end
    req_valid = 1'b0;
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL b2b_throughput: got %0d responses want 10", n);
    end
  endtask

`ifdef ALU_SEQ_STATS_EN
  task automatic test_stats();
    do_reset();
    total++;
    if (s1_op_count !== 8'd0) begin
      bad++;
      $display("FAIL stats_reset: got %0h want 0", s1_op_count);
    end
    resp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (s1_op_count !== 8'd1) begin
      bad++;
      $display("FAIL stats_one: got %0h want 1", s1_op_count);
    end
    for (int i = 0; i < 759; i++) tick();
    total++;
    if (s1_op_count !== 8'd254) begin
      bad++;
      $display("FAIL stats_254: got %0h want fe", s1_op_count);
    end
    for (int i = 0; i < 9; i++) tick();
    req_valid = 1'b0;
    total++;
    if (s1_op_count !== 8'hFF) begin
      bad++;
      $display("FAIL stats_sat: got %0h want ff", s1_op_count);
    end
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (s1_op_count !== 8'hFF) begin
      bad++;
      $display("FAIL stats_hold: got %0h want ff", s1_op_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_settle1();
    test_settle3();
    test_backpressure();
    test_abort();
    test_back_to_back();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
